// File: rtl/fft_ctrl_if.sv
// fft_ctrl_if -- bundle between the FFT sequencing controller and the rest
// of the system (start/done handshake plus the pipeline read/write controls).
//
// Signals (directions as seen by the controller):
//   i_start     in   start request, sampled only while the controller is idle
//   o_busy      out  high whenever a transform is in progress
//   o_done      out  one-cycle completion pulse
//   o_rd_en     out  read-address pair valid
//   o_rdaddr_A  out  butterfly top address
//   o_rdaddr_B  out  butterfly bottom address
//   o_wr_en     out  pipeline write strobe (o_rd_en delayed by the pipe latency)
//   o_span      out  one-hot butterfly span of the current stage
//
// Modports: master = controller side, slave = system/pipeline side.
interface fft_ctrl_if #(
    parameter int ADDR_SIZE = 5
);
    logic                 i_start;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_rd_en;
    logic [ADDR_SIZE-1:0] o_rdaddr_A;
    logic [ADDR_SIZE-1:0] o_rdaddr_B;
    logic                 o_wr_en;
    logic [ADDR_SIZE-1:0] o_span;

    modport master (
        input  i_start,
        output o_busy, o_done, o_rd_en, o_rdaddr_A, o_rdaddr_B, o_wr_en, o_span
    );

    modport slave (
        output i_start,
        input  o_busy, o_done, o_rd_en, o_rdaddr_A, o_rdaddr_B, o_wr_en, o_span
    );
endinterface

// File: rtl/fft_ctrl.sv
// fft_ctrl -- sequencing controller for a radix-2 FFT butterfly pipeline.
// Walks ADDR_SIZE stages; each stage issues N/2 butterfly read-address pairs
// (one per cycle) and then waits PIPE_LAT drain cycles so the last write of
// the stage lands before the next stage reads. The write enable is the read
// enable delayed by PIPE_LAT cycles.
//
// Ports:
//   i_CLK  clock, rising edge
//   i_RST  asynchronous active-low reset
//   bus    fft_ctrl_if.master: i_start in; o_busy, o_done, o_rd_en,
//          o_rdaddr_A, o_rdaddr_B, o_wr_en, o_span out
//
// Requires ADDR_SIZE >= 2 and PIPE_LAT >= 1.
module fft_ctrl #(
    parameter int ADDR_SIZE = 5,
    parameter int PIPE_LAT  = 2
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    fft_ctrl_if.master    bus
);
    localparam int KW = ADDR_SIZE - 1;                 // k counts N/2 butterflies
    localparam int SW = $clog2(ADDR_SIZE + 1);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [PIPE_LAT-1:0] wr_pipe_q, wr_pipe_d;

    logic                 rd_en;
    logic                 last_k, last_stage, last_drain;
    logic [ADDR_SIZE-1:0] k_ext, span, low_mask, addr_a, addr_b;

    assign rd_en      = (state_q == S_ISSUE);
    assign last_k     = &k_q;
    assign last_stage = (stage_q == SW'(ADDR_SIZE - 1));
    assign last_drain = (drain_q == DW'(PIPE_LAT - 1));

    // Butterfly addressing: insert a 0 at bit position 'stage' of k for the
    // top address; the bottom address sets that bit.
    assign k_ext    = {1'b0, k_q};
    assign span     = ADDR_SIZE'(1) << stage_q;
    assign low_mask = span - ADDR_SIZE'(1);
    assign addr_a   = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    assign addr_b   = addr_a | span;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            S_ISSUE: begin
                k_d = k_q + KW'(1);                     // wraps to 0 after N/2-1
                if (last_k) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (last_drain) begin
                    drain_d = '0;
                    if (last_stage) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + SW'(1);
                    end
                end
            end
            default: begin                              // S_DONE
                state_d = S_IDLE;
                stage_d = '0;
            end
        endcase
    end

    // Write-enable delay line; runs in every state so writes of the last
    // stage still emerge during DRAIN.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_wr_pipe
            if (gi == 0) begin : g_head
                assign wr_pipe_d[gi] = rd_en;
            end else begin : g_tail
                assign wr_pipe_d[gi] = wr_pipe_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            stage_q   <= '0;
            drain_q   <= '0;
            wr_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            stage_q   <= stage_d;
            drain_q   <= drain_d;
            wr_pipe_q <= wr_pipe_d;
        end
    end

    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_done     = (state_q == S_DONE);
    assign bus.o_rd_en    = rd_en;
    assign bus.o_rdaddr_A = rd_en ? addr_a : '0;
    assign bus.o_rdaddr_B = rd_en ? addr_b : '0;
    assign bus.o_wr_en    = wr_pipe_q[PIPE_LAT-1];
    assign bus.o_span     = span;
endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl -- self-checking bench for fft_ctrl. Two instances: the default
// configuration (ADDR_SIZE=5, PIPE_LAT=2) and a small one (3, 4). Expected
// behaviour comes from a closed-form timeline model: cycle c of a run is
// mapped to (stage, position within stage) by division, from which every
// output is derived arithmetically.
module tb_fft_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    fft_ctrl_if #(.ADDR_SIZE(5)) bus0 ();
    fft_ctrl_if #(.ADDR_SIZE(3)) bus1 ();

    fft_ctrl #(.ADDR_SIZE(5), .PIPE_LAT(2)) dut (
        .i_CLK (clk),
        .i_RST (rst_n),
        .bus   (bus0)
    );

    fft_ctrl #(.ADDR_SIZE(3), .PIPE_LAT(4)) dut_s (
        .i_CLK (clk),
        .i_RST (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference timeline. c is the cycle number within a run (cycle 1 is the
    // first ISSUE cycle after the start edge); c<1 or c>D means idle.
    function automatic void ref_model(input int c, input int as, input int pl,
                                      output logic [3:0] flags,
                                      output logic [31:0] a, output logic [31:0] b,
                                      output logic [31:0] span, output bit span_known);
        int h, per, d, s, r, w;
        h   = (1 << as) / 2;
        per = h + pl;
        d   = as * per + 1;
        flags = 4'b0000;                      // {busy, done, rd_en, wr_en}
        a = 0; b = 0; span = 1; span_known = 1'b1;
        if (c >= 1 && c <= d) flags[3] = 1'b1;
        if (c == d) begin
            flags[2]   = 1'b1;
            span_known = 1'b0;
        end
        if (c >= 1 && c < d) begin
            s    = (c - 1) / per;
            r    = (c - 1) % per;
            span = 1 << s;
            if (r < h) begin
                flags[1] = 1'b1;
                a = (r / (1 << s)) * (1 << (s + 1)) + r % (1 << s);
                b = a + (1 << s);
            end
        end
        w = c - pl;
        if (w >= 1 && w < d && ((w - 1) % per) < h) flags[0] = 1'b1;
    endfunction

    task automatic test_reset();
        logic [3:0] af0, af1;
        #2 rst_n = 1'b0;
        bus0.i_start = 1'b0;
        bus1.i_start = 1'b0;
        #3;
        tick();
        af0 = {bus0.o_busy, bus0.o_done, bus0.o_rd_en, bus0.o_wr_en};
        af1 = {bus1.o_busy, bus1.o_done, bus1.o_rd_en, bus1.o_wr_en};
        n_vec++;
        if (af0 !== 4'b0000 || bus0.o_rdaddr_A !== 5'd0 || bus0.o_rdaddr_B !== 5'd0 || bus0.o_span !== 5'd1) begin
            n_bad++;
            $display("FAIL reset_dut0: flags=%b A=%0d B=%0d span=%0d, want 0000 A=0 B=0 span=1",
                     af0, bus0.o_rdaddr_A, bus0.o_rdaddr_B, bus0.o_span);
        end
        n_vec++;
        if (af1 !== 4'b0000 || bus1.o_rdaddr_A !== 3'd0 || bus1.o_rdaddr_B !== 3'd0 || bus1.o_span !== 3'd1) begin
            n_bad++;
            $display("FAIL reset_dut1: flags=%b A=%0d B=%0d span=%0d, want 0000 A=0 B=0 span=1",
                     af1, bus1.o_rdaddr_A, bus1.o_rdaddr_B, bus1.o_span);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            af0 = {bus0.o_busy, bus0.o_done, bus0.o_rd_en, bus0.o_wr_en};
            n_vec++;
            if (af0 !== 4'b0000 || bus0.o_span !== 5'd1) begin
                n_bad++;
                $display("FAIL idle_after_reset: flags=%b span=%0d, want 0000 span=1", af0, bus0.o_span);
            end
        end
    endtask

    // Full run on the default instance; optional random start pulses while busy.
    task automatic test_single_run(input bit strays);
        localparam int D = 91;
        int spot_c [5] = '{1, 2, 42, 73, 88};
        int spot_a [5] = '{0, 2, 9, 0, 15};
        int spot_b [5] = '{1, 3, 13, 16, 31};
        logic [31:0] seen [5];
        logic [3:0]  ef, af;
        logic [31:0] ea, eb, es, aa, ab, asp;
        bit          sk;
        int          rd_cnt, wr_cnt, done_at, s;
        rd_cnt = 0; wr_cnt = 0; done_at = -1;
        for (int i = 0; i < 5; i++) seen[i] = '0;
        bus0.i_start = 1'b1;
        tick();
        bus0.i_start = 1'b0;
        for (int c = 1; c <= D + 5; c++) begin
            ref_model(c, 5, 2, ef, ea, eb, es, sk);
            af  = {bus0.o_busy, bus0.o_done, bus0.o_rd_en, bus0.o_wr_en};
            aa  = 32'(bus0.o_rdaddr_A);
            ab  = 32'(bus0.o_rdaddr_B);
            asp = 32'(bus0.o_span);
            n_vec++;
            if (af !== ef || aa !== ea || ab !== eb || (sk && asp !== es)) begin
                n_bad++;
                $display("FAIL run cyc %0d: got busy/done/rd/wr=%b A=%0d B=%0d span=%0d, want %b A=%0d B=%0d span=%0d",
                         c, af, aa, ab, asp, ef, ea, eb, es);
            end
            for (int i = 0; i < 5; i++) begin
                if (c == spot_c[i]) begin
                    n_vec++;
                    if (aa !== 32'(spot_a[i]) || ab !== 32'(spot_b[i])) begin
                        n_bad++;
                        $display("FAIL addr_spot cyc %0d: got (%0d,%0d), want (%0d,%0d)",
                                 c, aa, ab, spot_a[i], spot_b[i]);
                    end
                end
            end
            if (af[1] === 1'b1) rd_cnt++;
            if (af[0] === 1'b1) wr_cnt++;
            if (af[2] === 1'b1) done_at = c;
            if (af[1] === 1'b1 && c < D && aa < 32 && ab < 32) begin
                s = (c - 1) / 18;
                seen[s][aa[4:0]] = 1'b1;
                seen[s][ab[4:0]] = 1'b1;
            end
            if (strays && c <= D && (c == 5 || c == 50 || $urandom_range(0, 7) == 0))
                bus0.i_start = 1'b1;
            else
                bus0.i_start = 1'b0;
            tick();
        end
        bus0.i_start = 1'b0;
        n_vec++;
        if (rd_cnt != 80) begin
            n_bad++;
            $display("FAIL rd_count: got %0d, want 80", rd_cnt);
        end
        n_vec++;
        if (wr_cnt != 80) begin
            n_bad++;
            $display("FAIL wr_count: got %0d, want 80", wr_cnt);
        end
        n_vec++;
        if (done_at != D) begin
            n_bad++;
            $display("FAIL done_cycle: got %0d, want %0d", done_at, D);
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (seen[i] !== 32'hFFFF_FFFF) begin
                n_bad++;
                $display("FAIL stage_cover %0d: got %h, want ffffffff", i, seen[i]);
            end
        end
    endtask

    // Reset pulse in the middle of stage 2 with writes in flight.
    task automatic test_mid_reset();
        logic [3:0] af;
        bus0.i_start = 1'b1;
        tick();
        bus0.i_start = 1'b0;
        for (int c = 1; c < 40; c++) tick();
        rst_n = 1'b0;
        #1;
        af = {bus0.o_busy, bus0.o_done, bus0.o_rd_en, bus0.o_wr_en};
        n_vec++;
        if (af !== 4'b0000 || bus0.o_rdaddr_A !== 5'd0 || bus0.o_rdaddr_B !== 5'd0 || bus0.o_span !== 5'd1) begin
            n_bad++;
            $display("FAIL mid_reset_immediate: flags=%b A=%0d B=%0d span=%0d, want 0000 A=0 B=0 span=1",
                     af, bus0.o_rdaddr_A, bus0.o_rdaddr_B, bus0.o_span);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            af = {bus0.o_busy, bus0.o_done, bus0.o_rd_en, bus0.o_wr_en};
            n_vec++;
            if (af !== 4'b0000 || bus0.o_span !== 5'd1) begin
                n_bad++;
                $display("FAIL after_reset %0d: flags=%b span=%0d, want 0000 span=1", i, af, bus0.o_span);
            end
        end
    endtask

    // i_start held high: runs repeat every D+1 cycles, each from IDLE.
    task automatic test_back_to_back();
        localparam int D = 91;
        logic [3:0]  ef, af;
        logic [31:0] ea, eb, es, aa, ab, asp;
        bit          sk;
        int          local_c, n_done;
        n_done = 0;
        bus0.i_start = 1'b1;
        tick();
        for (int c = 1; c <= 2 * (D + 1) + 2; c++) begin
            local_c = (c > 2 * (D + 1)) ? 0 : ((c - 1) % (D + 1)) + 1;
            ref_model(local_c, 5, 2, ef, ea, eb, es, sk);
            af  = {bus0.o_busy, bus0.o_done, bus0.o_rd_en, bus0.o_wr_en};
            aa  = 32'(bus0.o_rdaddr_A);
            ab  = 32'(bus0.o_rdaddr_B);
            asp = 32'(bus0.o_span);
            n_vec++;
            if (af !== ef || aa !== ea || ab !== eb || (sk && asp !== es)) begin
                n_bad++;
                $display("FAIL b2b cyc %0d: got busy/done/rd/wr=%b A=%0d B=%0d span=%0d, want %b A=%0d B=%0d span=%0d",
                         c, af, aa, ab, asp, ef, ea, eb, es);
            end
            if (af[2] === 1'b1) n_done++;
            if (c == 2 * (D + 1)) bus0.i_start = 1'b0;
            tick();
        end
        n_vec++;
        if (n_done != 2) begin
            n_bad++;
            $display("FAIL b2b_done_count: got %0d, want 2", n_done);
        end
    endtask

    // Small configuration: ADDR_SIZE=3, PIPE_LAT=4.
    task automatic test_param_sweep();
        localparam int D = 25;
        logic [3:0]  ef, af;
        logic [31:0] ea, eb, es, aa, ab, asp;
        bit          sk;
        int          wr_cnt, done_at;
        wr_cnt = 0; done_at = -1;
        bus1.i_start = 1'b1;
        tick();
        bus1.i_start = 1'b0;
        for (int c = 1; c <= D + 4; c++) begin
            ref_model(c, 3, 4, ef, ea, eb, es, sk);
            af  = {bus1.o_busy, bus1.o_done, bus1.o_rd_en, bus1.o_wr_en};
            aa  = 32'(bus1.o_rdaddr_A);
            ab  = 32'(bus1.o_rdaddr_B);
            asp = 32'(bus1.o_span);
            n_vec++;
            if (af !== ef || aa !== ea || ab !== eb || (sk && asp !== es)) begin
                n_bad++;
                $display("FAIL sweep cyc %0d: got busy/done/rd/wr=%b A=%0d B=%0d span=%0d, want %b A=%0d B=%0d span=%0d",
                         c, af, aa, ab, asp, ef, ea, eb, es);
            end
            if (af[0] === 1'b1) wr_cnt++;
            if (af[2] === 1'b1) done_at = c;
            bus1.i_start = (c < D) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        bus1.i_start = 1'b0;
        n_vec++;
        if (wr_cnt != 12) begin
            n_bad++;
            $display("FAIL sweep_wr_count: got %0d, want 12", wr_cnt);
        end
        n_vec++;
        if (done_at != D) begin
            n_bad++;
            $display("FAIL sweep_done_cycle: got %0d, want %0d", done_at, D);
        end
    endtask

    initial begin
        bus0.i_start = 1'b0;
        bus1.i_start = 1'b0;
        test_reset();
        test_single_run(1'b0);
        test_single_run(1'b1);
        test_mid_reset();
        test_single_run(1'b0);
        test_back_to_back();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
